mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
- Sequences every load/store leaving the EX/MEM register onto a variable-latency, single-ported data memory.
- Drives the memory request/ready handshake and freezes the pipeline with `stall` while an access is outstanding.
- Returns load data to the MEM/WB path.
- Store data arrives already resolved by the memory forwarding logic. This block only schedules the access.

Parameters:
- ADDR_W, 32, width of the data address
- DATA_W, 32, width of load/store data
- TIMEOUT_CYCLES, 16, max BUSY cycles without mem_ready before abort (legal range 2..255)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ex_mem_memread  in  1  instruction in EX/MEM is a load
- ex_mem_memwrite  in  1  instruction in EX/MEM is a store
- ex_mem_addr  in  ADDR_W  effective address
- ex_mem_wdata  in  DATA_W  store data (post-forwarding)
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  address to memory; valid while mem_req
- mem_wdata  out  DATA_W  write data; valid while mem_req and mem_we
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  DATA_W  read data; valid when mem_ready and !mem_we
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- load_data  out  DATA_W  last completed load value
- load_valid  out  1  one-cycle pulse: load_data updated
- timeout_err  out  1  sticky: an access was aborted

Behaviour:
- Reset, applied at any clock edge, including mid-access:
  - state goes to IDLE.
  - mem_req, mem_we, load_valid and timeout_err go to 0.
  - mem_addr, mem_wdata and load_data go to 0.
  - the cycle counter goes to 0.
  - No memory handshake survives reset.
- FSM state IDLE:
  - When ex_mem_memread or ex_mem_memwrite is 1, `stall` = 1 combinationally in the same cycle.
  - On the next edge, latch addr, wdata and we (we = ex_mem_memwrite), clear the counter, go to BUSY.
  - Both memread and memwrite = 1 is treated as a write; the read is ignored.
  - mem_ready is ignored in IDLE.
- FSM state BUSY:
  - mem_req = 1 and stall = 1.
  - mem_addr, mem_we and mem_wdata are held constant from the registered copies.
  - On an edge with mem_ready = 1, go to DONE. For a read, capture mem_rdata into load_data.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no ready, set timeout_err, force load_data = 0 for reads, and go to DONE.
- FSM state DONE (exactly one cycle):
  - mem_req = 0 and stall = 0, so the pipeline advances on this edge.
  - load_valid = 1 only if the access was a read, including an aborted read.
  - EX/MEM inputs are not sampled, so the same instruction never retriggers.
  - Always go to IDLE.
- Latency:
  - A zero-wait access (ready in the first BUSY cycle) costs 2 stall cycles.
  - An N-wait access costs N+2.
  - Back-to-back memory instructions each pay the full cost; the IDLE detect cycle is not skipped.
- mem_req is registered from state, not from the inputs.
- stall is the only combinational output, and it depends only on state plus ex_mem_memread/memwrite.
- timeout_err clears only on reset.
- load_data holds its value until the next read completes.

Decomposition:
- Shared package / header holds:
  - state encoding localparams: IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10
  - DATA_W and ADDR_W defaults, shared with the other pipeline units
- One sub-module is natural: mem_timeout_counter.
  - Ports: clk, reset, clear, enable; output `expired`.
  - Parameterised by TIMEOUT_CYCLES; width $clog2(TIMEOUT_CYCLES).
- Everything else stays in the top-level FSM.

Test Plan:
- Reset held 3 cycles mid-BUSY (read to 0x40 outstanding) -> next cycle mem_req = 0, stall = 0, state IDLE, load_data = 0, timeout_err = 0; a later mem_ready pulse has no effect.
- Load from 0x0000_0010, mem_ready = 1 in first BUSY cycle, mem_rdata = 0xDEAD_BEEF -> stall high exactly 2 cycles, mem_we = 0, load_valid pulses 1 cycle, load_data = 0xDEAD_BEEF.
- Store 0x1234_5678 to 0x20, mem_ready after 3 wait cycles -> mem_req high 4 cycles with addr/wdata constant, mem_we = 1, stall 5 cycles, load_valid never asserts.
- Simultaneous memread = memwrite = 1, addr 0x8, wdata 0xA5A5_A5A5 -> mem_we = 1; treated as a store, no load_valid.
- mem_ready never asserted, TIMEOUT_CYCLES = 16, load -> mem_req high exactly 16 cycles, then DONE; timeout_err = 1 and stays 1; load_data = 0; load_valid pulses once.
- Store then load back-to-back, both zero-wait -> two separate IDLE→BUSY→DONE sequences, stall pattern 1,1,0,1,1,0, and a single mem_req pulse per access.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the data-memory access sequencer: FSM encoding and
// default datapath widths used across the pipeline units.
package mem_access_controller_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_controller_timeout.sv
// BUSY-cycle counter: counts cycles without mem_ready and flags the last
// cycle allowed before the access is aborted.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)          cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_access_controller.sv
// Schedules one EX/MEM load/store at a time onto a variable-latency memory,
// stalling the front of the pipeline until the access completes or aborts.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              timeout_err
);

  state_t state, state_nxt;
  logic   expired;

  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  ((state == BUSY) && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE deliberately ignores EX/MEM so a held instruction cannot retrigger.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (ex_mem_memread || ex_mem_memwrite) begin
        stall     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ready || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_req    <= (state_nxt == BUSY);
      load_valid <= 1'b0;
      case (state)
        IDLE: if (state_nxt == BUSY) begin
          mem_addr  <= ex_mem_addr;
          mem_wdata <= ex_mem_wdata;
          mem_we    <= ex_mem_memwrite;
        end
        BUSY: if (mem_ready) begin
          if (!mem_we) begin
            load_data  <= mem_rdata;
            load_valid <= 1'b1;
          end
        end else if (expired) begin
          // Aborted reads still report, with zeroed data, so WB is not left waiting.
          timeout_err <= 1'b1;
          if (!mem_we) begin
            load_data  <= '0;
            load_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: per-scenario tasks with
// hand-computed expectations against a cycle-level memory stub.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_memread, ex_mem_memwrite;
  logic [31:0] ex_mem_addr, ex_mem_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .timeout_err(timeout_err)
  );

  // Holds one instruction in EX/MEM until the pipeline advances (first stall=0
  // after stalling). Memory answers after 'waits' BUSY cycles; waits<0 = never.
  // Entered and left at posedge+1.
  task automatic drive_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input int waits, input logic [31:0] rdat,
                              output int n_stall, output int n_req, output int n_lv,
                              output bit hold_ok, output logic [7:0] pat);
    int  busy = 0;
    bit  done = 0;
    n_stall = 0; n_req = 0; n_lv = 0; hold_ok = 1; pat = '0;
    ex_mem_memread = rd; ex_mem_memwrite = wr; ex_mem_addr = a; ex_mem_wdata = d;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_ready = mem_req && (waits >= 0) && (busy == waits);
      mem_rdata = mem_ready ? rdat : 32'h0;
      @(negedge clk);
      pat = {pat[6:0], stall};
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        busy++;
        if (mem_addr !== a || mem_we !== wr || (wr && mem_wdata !== d)) hold_ok = 0;
      end
      if (load_valid) n_lv++;
      if (!stall && n_stall > 0) done = 1;
      @(posedge clk); #1;
    end
    ex_mem_memread = 0; ex_mem_memwrite = 0; mem_ready = 0; mem_rdata = 0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL access_bound: access never completed within 64 cycles");
    end
  endtask

  task automatic test_reset;
    reset = 1; ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_addr = 0; ex_mem_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, stall, load_valid, timeout_err} !== 5'b0 ||
        load_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: req=%b we=%b stall=%b lv=%b to=%b ld=%h addr=%h wd=%h, required all 0",
               mem_req, mem_we, stall, load_valid, timeout_err, load_data, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    int ns, nr, nl; bit ok; logic [7:0] p;
    drive_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, ns, nr, nl, ok, p);
    vectors++;
    if (ns !== 2 || nr !== 1 || nl !== 1 || !ok) begin
      miscompares++;
      $display("FAIL load_zero_wait: stall=%0d req=%0d lv=%0d hold=%0d, required 2 1 1 1", ns, nr, nl, ok);
    end
    @(negedge clk);
    vectors++;
    if (load_data !== 32'hDEAD_BEEF || load_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_data: ld=%h lv=%b, required deadbeef 0", load_data, load_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy;
    ex_mem_memread = 1; ex_mem_addr = 32'h40;
    repeat (4) @(posedge clk);
    #1 reset = 1; ex_mem_memread = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 0 || stall !== 0 || dut.state !== 2'b00 || load_data !== 32'h0 || timeout_err !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_busy: req=%b stall=%b st=%b ld=%h to=%b, required 0 0 00 0 0",
               mem_req, stall, dut.state, load_data, timeout_err);
    end
    @(posedge clk); #1 mem_ready = 1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1 mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 0 || load_valid !== 0 || dut.state !== 2'b00 || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL stray_ready: req=%b lv=%b st=%b ld=%h, required 0 0 00 0",
               mem_req, load_valid, dut.state, load_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_wait;
    int ns, nr, nl; bit ok; logic [7:0] p;
    drive_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, 32'h0, ns, nr, nl, ok, p);
    vectors++;
    if (ns !== 5 || nr !== 4 || nl !== 0 || !ok) begin
      miscompares++;
      $display("FAIL store_3wait: stall=%0d req=%0d lv=%0d hold=%0d, required 5 4 0 1", ns, nr, nl, ok);
    end
  endtask

  task automatic test_read_write_both;
    int ns, nr, nl; bit ok; logic [7:0] p;
    // Seed load_data first so a wrongly treated read would visibly change it.
    drive_access(1'b1, 1'b0, 32'h4, 32'h0, 1, 32'h7777_0001, ns, nr, nl, ok, p);
    drive_access(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, 0, 32'h5A5A_5A5A, ns, nr, nl, ok, p);
    vectors++;
    if (ns !== 2 || nr !== 1 || nl !== 0 || !ok || load_data !== 32'h7777_0001) begin
      miscompares++;
      $display("FAIL rd_wr_both: stall=%0d req=%0d lv=%0d we_hold=%0d ld=%h, required 2 1 0 1 77770001",
               ns, nr, nl, ok, load_data);
    end
  endtask

  task automatic test_timeout;
    int ns, nr, nl; bit ok; logic [7:0] p;
    vectors++;
    if (timeout_err !== 0) begin
      miscompares++;
      $display("FAIL timeout_pre: to=%b, required 0", timeout_err);
    end
    drive_access(1'b1, 1'b0, 32'h100, 32'h0, -1, 32'h0, ns, nr, nl, ok, p);
    vectors++;
    if (nr !== 16 || ns !== 17 || nl !== 1 || !ok) begin
      miscompares++;
      $display("FAIL timeout_load: req=%0d stall=%0d lv=%0d hold=%0d, required 16 17 1 1", nr, ns, nl, ok);
    end
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1 || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_flags: to=%b ld=%h, required 1 0", timeout_err, load_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int ns, nr, nl; bit ok; logic [7:0] p1, p2;
    drive_access(1'b0, 1'b1, 32'h30, 32'hFEED_0001, 0, 32'h0, ns, nr, nl, ok, p1);
    vectors++;
    if (p1 !== 8'b0000_0110 || nr !== 1 || nl !== 0 || !ok) begin
      miscompares++;
      $display("FAIL b2b_store: pat=%b req=%0d lv=%0d hold=%0d, required 00000110 1 0 1", p1, nr, nl, ok);
    end
    drive_access(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'hCAFE_F00D, ns, nr, nl, ok, p2);
    vectors++;
    if (p2 !== 8'b0000_0110 || nr !== 1 || nl !== 1 || !ok) begin
      miscompares++;
      $display("FAIL b2b_load: pat=%b req=%0d lv=%0d hold=%0d, required 00000110 1 1 1", p2, nr, nl, ok);
    end
    @(negedge clk);
    vectors++;
    if (load_data !== 32'hCAFE_F00D || timeout_err !== 1 || stall !== 0 || mem_req !== 0) begin
      miscompares++;
      $display("FAIL b2b_final: ld=%h to=%b stall=%b req=%b, required cafef00d 1 0 0",
               load_data, timeout_err, stall, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_reset_mid_busy();
    test_store_wait();
    test_read_write_both();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
